// File: rtl/conv_encoder.sv
// conv_encoder
// ----------------------------------------------------------------------------
// Serial rate-1/2, constraint-length-7 convolutional encoder. Each accepted
// information bit b is combined with the six previous bits s[5:0] (s[5] is the
// newest) into v = {b, s}, and produces two coded bits c0 = ^(v & G0) followed
// by c1 = ^(v & G1). The coded stream feeds the downstream interleaver one bit
// per valid cycle, so one input bit is accepted at most every second cycle.
//
// Optional feature, selected by the macro CONV_ENC_TAIL_EN:
//   defined   - frames of FRAME_LEN information bits are closed with six zero
//               tail bits (12 coded bits), leaving the encoder state at zero.
//   undefined - continuous encoding, no frame boundaries; FRAME_LEN unused.
//
// Parameters:
//   FRAME_LEN  information bits per frame (>= 1), tail build only
//   G0, G1     generator polynomials for the first / second coded bit
//
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous active-high reset
//   i_data   in   information bit, taken when i_dv && o_ready
//   i_dv     in   input valid
//   o_ready  out  encoder accepts a bit this cycle (registered)
//   o_data   out  coded bit (registered, holds when o_dv = 0)
//   o_dv     out  o_data valid (registered)
// ----------------------------------------------------------------------------
module conv_encoder #(
  parameter int unsigned FRAME_LEN = 64,
  parameter logic [6:0]  G0        = 7'o171,
  parameter logic [6:0]  G1        = 7'o133
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  input  logic i_dv,
  output logic o_ready,
  output logic o_data,
  output logic o_dv
);

  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("conv_encoder: FRAME_LEN must be at least 1");
  end

  // Even-parity reduction of a masked encode vector.
  function automatic logic parity7(input logic [6:0] v);
    return ^v;
  endfunction

  // Both coded bits for bit b on state s: [1] = c0 (sent first), [0] = c1.
  function automatic logic [1:0] encode(input logic b, input logic [5:0] s);
    logic [6:0] v;
    v = {b, s};
    return {parity7(v & G0), parity7(v & G1)};
  endfunction

  logic [5:0] sr_r, sr_s;       // encoder shift state, sr_r[5] newest
  logic       pend_r, pend_s;   // c1 waiting for the second output slot
  logic       phase_r, phase_s; // 1: second coded bit is due this edge
  logic       ready_r, ready_s;
  logic       data_r, data_s;
  logic       dv_r, dv_s;
  logic       accept_s;
  logic       in_bit_s;
  logic [1:0] code_s;

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } state_t;

  localparam int unsigned     CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;     // accepted bits in the current frame
  logic [2:0]       tcnt_r, tcnt_s;   // tail bits already completed
  logic             term_r, term_s;   // last frame bit taken; tail follows its c1
`endif

  // ready_r is only ever high in the first phase of DATA, so this is the accept.
  assign accept_s = i_dv & ready_r;

`ifdef CONV_ENC_TAIL_EN
  // Tail bits are internal zeros; data bits come from the input.
  always_comb begin
    if (state_r == ST_TAIL) begin
      in_bit_s = 1'b0;
    end else begin
      in_bit_s = i_data;
    end
  end
`else
  // Every encoded bit comes from the input.
  always_comb begin
    in_bit_s = i_data;
  end
`endif

  // Coded pair for the bit entering the encoder this cycle.
  always_comb begin
    code_s = encode(in_bit_s, sr_r);
  end

`ifdef CONV_ENC_TAIL_EN
  // Next-state and output logic: frame counting, zero tail, two-phase output.
  always_comb begin
    state_s = state_r;
    sr_s    = sr_r;
    pend_s  = pend_r;
    phase_s = phase_r;
    ready_s = 1'b0;
    data_s  = data_r;
    dv_s    = 1'b0;
    cnt_s   = cnt_r;
    tcnt_s  = tcnt_r;
    term_s  = term_r;
    case (state_r)
      ST_DATA: begin
        if (phase_r) begin
          data_s  = pend_r;
          dv_s    = 1'b1;
          phase_s = 1'b0;
          if (term_r) begin
            // Tail starts straight after this c1, so no input slot opens.
            state_s = ST_TAIL;
            term_s  = 1'b0;
            ready_s = 1'b0;
          end else begin
            ready_s = 1'b1;
          end
        end else if (accept_s) begin
          data_s  = code_s[1];
          pend_s  = code_s[0];
          dv_s    = 1'b1;
          phase_s = 1'b1;
          sr_s    = {in_bit_s, sr_r[5:1]};
          ready_s = 1'b0;
          if (cnt_r == LAST_CNT) begin
            cnt_s  = {CNT_W{1'b0}};
            term_s = 1'b1;
          end else begin
            cnt_s  = cnt_r + CNT_W'(1);
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_TAIL: begin
        if (phase_r) begin
          data_s  = pend_r;
          dv_s    = 1'b1;
          phase_s = 1'b0;
          if (tcnt_r == 3'd5) begin
            // Six zeros have flushed the state; clear it explicitly anyway.
            tcnt_s  = 3'd0;
            state_s = ST_DATA;
            sr_s    = 6'd0;
          end else begin
            tcnt_s  = tcnt_r + 3'd1;
          end
        end else begin
          data_s  = code_s[1];
          pend_s  = code_s[0];
          dv_s    = 1'b1;
          phase_s = 1'b1;
          sr_s    = {in_bit_s, sr_r[5:1]};
        end
      end
      default: begin
        state_s = ST_DATA;
        sr_s    = 6'd0;
        pend_s  = 1'b0;
        phase_s = 1'b0;
        cnt_s   = {CNT_W{1'b0}};
        tcnt_s  = 3'd0;
        term_s  = 1'b0;
      end
    endcase
  end

  // Frame/tail state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_DATA;
      cnt_r   <= {CNT_W{1'b0}};
      tcnt_r  <= 3'd0;
      term_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tcnt_r  <= tcnt_s;
      term_r  <= term_s;
    end
  end
`else
  // Next-state and output logic: continuous two-phase encoding.
  always_comb begin
    sr_s    = sr_r;
    pend_s  = pend_r;
    phase_s = phase_r;
    ready_s = 1'b0;
    data_s  = data_r;
    dv_s    = 1'b0;
    if (phase_r) begin
      data_s  = pend_r;
      dv_s    = 1'b1;
      phase_s = 1'b0;
      ready_s = 1'b1;
    end else if (accept_s) begin
      data_s  = code_s[1];
      pend_s  = code_s[0];
      dv_s    = 1'b1;
      phase_s = 1'b1;
      sr_s    = {in_bit_s, sr_r[5:1]};
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end
`endif

  // Encoder state and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_r    <= 6'd0;
      pend_r  <= 1'b0;
      phase_r <= 1'b0;
      ready_r <= 1'b0;
      data_r  <= 1'b0;
      dv_r    <= 1'b0;
    end else begin
      sr_r    <= sr_s;
      pend_r  <= pend_s;
      phase_r <= phase_s;
      ready_r <= ready_s;
      data_r  <= data_s;
      dv_r    <= dv_s;
    end
  end

  assign o_ready = ready_r;
  assign o_data  = data_r;
  assign o_dv    = dv_r;

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder
// Self-checking bench for conv_encoder. A queue-based reference model predicts
// o_ready / o_dv / o_data every cycle; literal coded sequences pin the model.
// Honours CONV_ENC_TAIL_EN the same way the design does.
module tb_conv_encoder;

  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned GEN0      = 32'o171;
  localparam int unsigned GEN1      = 32'o133;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic i_data = 1'b0;
  logic i_dv   = 1'b0;
  logic o_ready;
  logic o_data;
  logic o_dv;

  int checks = 0;
  int errors = 0;

  conv_encoder #(
    .FRAME_LEN(FRAME_LEN),
    .G0       (7'o171),
    .G1       (7'o133)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (i_data),
    .i_dv   (i_dv),
    .o_ready(o_ready),
    .o_data (o_data),
    .o_dv   (o_dv)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned sh = 0;        // six previous bits, bit 5 newest
  bit          q[$];          // coded bits still to be emitted
  bit          qt[$];         // 1 where the matching q entry is a tail bit
  int          cnt = 0;
  bit          exp_ready = 1'b0;
  bit          exp_dv    = 1'b0;
  bit          exp_data  = 1'b0;
  bit          got[$];        // DUT coded bits captured on o_dv cycles

  function automatic bit par(input int unsigned x);
    return bit'($countones(x) % 2);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, req, $time);
    end
  endtask

  task automatic model_enc(input bit b, input bit is_tail);
    int unsigned v;
    v = (int'(b) << 6) | sh;
    q.push_back(par(v & GEN0));
    qt.push_back(is_tail);
    q.push_back(par(v & GEN1));
    qt.push_back(is_tail);
    sh = (v >> 1) & 32'h3f;
  endtask

  task automatic model_step();
    bit popped_tail;
    popped_tail = 1'b0;
    if (i_dv && exp_ready) begin
      model_enc(i_data, 1'b0);
`ifdef CONV_ENC_TAIL_EN
      cnt++;
      if (cnt == FRAME_LEN) begin
        cnt = 0;
        for (int k = 0; k < 6; k++) model_enc(1'b0, 1'b1);
      end
`endif
    end
    if (q.size() > 0) begin
      exp_data    = q.pop_front();
      popped_tail = qt.pop_front();
      exp_dv      = 1'b1;
    end else begin
      exp_dv      = 1'b0;
    end
    // An input slot opens once nothing is queued, one cycle late after a tail.
    exp_ready = (q.size() == 0) && !popped_tail;
  endtask

  // Model advances on every clock edge; reset clears it asynchronously.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sh = 0; cnt = 0;
        q.delete(); qt.delete();
        exp_ready = 1'b0; exp_dv = 1'b0; exp_data = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Compare DUT against model mid-cycle and capture emitted bits.
  initial begin
    forever begin
      @(negedge clk);
      chk("ready", int'(o_ready), int'(exp_ready));
      chk("dv",    int'(o_dv),    int'(exp_dv));
      chk("data",  int'(o_data),  int'(exp_data));
      if (o_dv === 1'b1) got.push_back(o_data);
    end
  end

  // Offer bits MSB first with i_dv high, randomising data on refused cycles.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      i_dv = 1'b1;
      while (!exp_ready && g < 100) begin
        i_data = 1'($urandom);
        @(posedge clk); #1;
        g++;
      end
      chk("send_timeout", int'(g < 100), 1);
      i_data = bits[n-1-i];
      @(posedge clk); #1;
    end
    i_dv = 1'b0;
  endtask

  // Wait (bounded) for n captured bits and compare them, first bit as MSB.
  task automatic expect_bits(input string name, input logic [31:0] req, input int n);
    int g;
    logic [31:0] act;
    g = 0;
    while (got.size() < n && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_count"}, int'(got.size() >= n), 1);
    act = 32'd0;
    for (int i = 0; i < n && i < got.size(); i++) act[n-1-i] = got[i];
    chk(name, int'(act), int'(req));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", int'(o_ready), 0);
    chk("reset_dv",    int'(o_dv),    0);
    chk("reset_data",  int'(o_data),  0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", int'(o_ready), 1);

    // Impulse / terminated frame with literal expectations
    got.delete();
`ifdef CONV_ENC_TAIL_EN
    send_bits(32'b1000, 4);
    expect_bits("tail_frame", 32'b11101111000111000000, 20);
`else
    send_bits(32'b1000000, 7);
    expect_bits("impulse", 32'b11101111000111, 14);
`endif
    repeat (4) @(posedge clk); #1;

    // Reset during the third tail bit (or mid-stream without tail)
    send_bits(32'b1011, 4);
    i_dv = 1'b1; i_data = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_dv",    int'(o_dv),    0);
    chk("rst_async_ready", int'(o_ready), 0);
    chk("rst_async_data",  int'(o_data),  0);
    @(posedge clk); #1;
    i_dv = 1'b0;
    rst  = 1'b0;
    got.delete();
    send_bits(32'b1, 1);
    expect_bits("after_reset_one", 32'b11, 2);
    repeat (20) @(posedge clk); #1;

    // Back-to-back frames of random bits
    send_bits($urandom, 8);
    repeat (30) @(posedge clk); #1;

    // Gapped input: one-cycle i_dv pulse every 5 cycles
    for (int i = 0; i < 30; i++) begin
      i_dv = 1'b1; i_data = 1'($urandom);
      @(posedge clk); #1;
      i_dv = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end

    // Random valid pattern with occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      i_dv   = ($urandom_range(0, 3) != 0);
      i_data = 1'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    i_dv = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
